// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: one ALU_bit_slice driven LSB first, with a carry flip-flop closing the chain
// between cycles. Result and N/Z/C/V flags are committed together on the edge that leaves DONE.
module ALU_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic [2:0] op_select,
  output logic       alu_bit,
  output logic       carry_out
);
  logic b_eff;
  logic sum;
  logic cout;

  always_comb begin
    // SUB is A + ~B + carry_in, with the carry FF preloaded to 1 for the first bit.
    b_eff = op_select[0] ? ~b : b;
    sum   = a ^ b_eff ^ carry_in;
    cout  = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
    unique case (op_select)
      3'b000:  alu_bit = b;
      3'b010:  alu_bit = sum;
      3'b011:  alu_bit = sum;
      3'b100:  alu_bit = a & b;
      3'b101:  alu_bit = a | b;
      3'b110:  alu_bit = a ^ b;
      default: alu_bit = 1'b0;
    endcase
    carry_out = (op_select[2:1] == 2'b01) ? cout : 1'b0;
  end
endmodule

module serial_alu_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op_select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q, result_q;
  logic [2:0]         op_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic               carry_q, cin_msb_q;
  logic               done_q, neg_q, zero_q, cout_q, ovf_q;
  logic               slice_bit, slice_cout;
  logic               last_bit, arith_op;

  assign last_bit = (bit_idx_q == IDX_W'(WIDTH - 1));
  assign arith_op = (op_q[2:1] == 2'b01);

  ALU_bit_slice u_slice (
    .a         (a_sh_q[bit_idx_q]),
    .b         (b_sh_q[bit_idx_q]),
    .carry_in  (carry_q),
    .op_select (op_q),
    .alu_bit   (slice_bit),
    .carry_out (slice_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      result_q  <= '0;
      op_q      <= '0;
      bit_idx_q <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q    <= A;
            b_sh_q    <= B;
            op_q      <= op_select;
            bit_idx_q <= '0;
            carry_q   <= op_select[0] & (op_select[2:1] == 2'b01);
          end
        end
        RUN: begin
          res_sh_q[bit_idx_q] <= slice_bit;
          carry_q             <= slice_cout;
          // The carry entering the MSB is needed later for signed overflow.
          if (last_bit) cin_msb_q <= carry_q;
          else          bit_idx_q <= bit_idx_q + 1'b1;
        end
        DONE: begin
          result_q <= res_sh_q;
          neg_q    <= res_sh_q[WIDTH-1];
          zero_q   <= ~|res_sh_q;
          cout_q   <= arith_op & carry_q;
          ovf_q    <= arith_op & (cin_msb_q ^ carry_q);
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = done_q;
  assign result    = result_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer: WIDTH=8 and WIDTH=64 instances checked against a reference
// arithmetic model through an expected-result queue, plus fixed vectors and reset/busy scenarios.
module tb_serial_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        busy8, done8, n8, z8, c8, v8;
  logic [1:0]  st8;
  // WIDTH=64 instance signals
  logic        start64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, res64;
  logic        busy64, done64, n64, z64, c64, v64;
  logic [1:0]  st64;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [67:0] exp_q[$];
  logic [67:0] exp64_q[$];

  serial_alu_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op_select(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result(res8), .negative(n8), .zero(z8),
    .carry_out(c8), .overflow(v8), .state_dbg(st8)
  );

  serial_alu_sequencer #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .start(start64), .op_select(op64), .A(a64), .B(b64),
    .busy(busy64), .done(done64), .result(res64), .negative(n64), .zero(z64),
    .carry_out(c64), .overflow(v64), .state_dbg(st64)
  );

  // Reference: {result[63:0], N, Z, C, V} using whole-word arithmetic.
  function automatic logic [67:0] model(input int w, input logic [2:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [64:0] s;
    logic [63:0] mask, a, b, r;
    logic c, v;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'b000: r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & mask;
        c = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, (~b) & mask} + 65'd1;
        r = s[63:0] & mask;
        c = s[w];
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = '0;
    endcase
    return {r, r[w-1], (r == 64'd0), c, v};
  endfunction

  task automatic run_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r_out, output logic [3:0] f_out);
    int k;
    logic [67:0] exp_v, got;
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    exp_q.push_back(model(8, op, {56'd0, a}, {56'd0, b}));
    @(negedge clk);
    start8 = 1'b0;
    chk_cnt++;
    if (busy8 !== 1'b1) $display("FAIL busy8_after_start got=%b exp=1", busy8);
    else pass_cnt++;
    k = 0;
    while (done8 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk_cnt++;
    if (k !== 9) $display("FAIL latency8 op=%b got=%0d exp=9", op, k);
    else pass_cnt++;
    if (done8 === 1'b1) begin
      got = {56'd0, res8, n8, z8, c8, v8};
      chk_cnt++;
      if (exp_q.size() == 0) $display("FAIL sb8_empty got=%h", got);
      else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) $display("FAIL sb8 op=%b a=%h b=%h got=%h exp=%h", op, a, b, got, exp_v);
        else pass_cnt++;
      end
    end
    r_out = res8;
    f_out = {n8, z8, c8, v8};
    @(negedge clk);
    chk_cnt++;
    if (done8 !== 1'b0) $display("FAIL done8_pulse got=%b exp=0", done8);
    else pass_cnt++;
  endtask

  task automatic run_op64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] r_out, output logic [3:0] f_out);
    int k;
    logic [67:0] exp_v, got;
    @(negedge clk);
    op64 = op; a64 = a; b64 = b; start64 = 1'b1;
    exp64_q.push_back(model(64, op, a, b));
    @(negedge clk);
    start64 = 1'b0;
    k = 0;
    while (done64 !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk_cnt++;
    if (k !== 65) $display("FAIL latency64 op=%b got=%0d exp=65", op, k);
    else pass_cnt++;
    if (done64 === 1'b1) begin
      got = {res64, n64, z64, c64, v64};
      chk_cnt++;
      if (exp64_q.size() == 0) $display("FAIL sb64_empty got=%h", got);
      else begin
        exp_v = exp64_q.pop_front();
        if (got !== exp_v) $display("FAIL sb64 op=%b got=%h exp=%h", op, got, exp_v);
        else pass_cnt++;
      end
    end
    r_out = res64;
    f_out = {n64, z64, c64, v64};
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    start64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
    #1;
    chk_cnt++;
    if ({busy8, done8, res8, n8, z8, c8, v8, st8} !== '0)
      $display("FAIL reset8 got=%b%b %h %b%b%b%b st=%0d exp=all zero", busy8, done8, res8, n8, z8, c8, v8, st8);
    else pass_cnt++;
    chk_cnt++;
    if ({busy64, done64, res64, n64, z64, c64, v64, st64} !== '0)
      $display("FAIL reset64 got=%b%b %h st=%0d exp=all zero", busy64, done64, res64, st64);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fixed_vectors();
    logic [7:0] r;
    logic [3:0] f;
    run_op8(3'b010, 8'h7F, 8'h01, r, f);
    chk_cnt++; if ({r, f} !== {8'h80, 4'b1001}) $display("FAIL add_7f_01 got=%h/%b exp=80/1001", r, f); else pass_cnt++;
    run_op8(3'b011, 8'h05, 8'h05, r, f);
    chk_cnt++; if ({r, f} !== {8'h00, 4'b0110}) $display("FAIL sub_eq got=%h/%b exp=00/0110", r, f); else pass_cnt++;
    run_op8(3'b011, 8'h00, 8'h01, r, f);
    chk_cnt++; if ({r, f} !== {8'hFF, 4'b1000}) $display("FAIL sub_borrow got=%h/%b exp=ff/1000", r, f); else pass_cnt++;
    run_op8(3'b100, 8'hF0, 8'h3C, r, f);
    chk_cnt++; if ({r, f} !== {8'h30, 4'b0000}) $display("FAIL and got=%h/%b exp=30/0000", r, f); else pass_cnt++;
    run_op8(3'b101, 8'hF0, 8'h3C, r, f);
    chk_cnt++; if ({r, f} !== {8'hFC, 4'b1000}) $display("FAIL or got=%h/%b exp=fc/1000", r, f); else pass_cnt++;
    run_op8(3'b110, 8'hAA, 8'hAA, r, f);
    chk_cnt++; if ({r, f} !== {8'h00, 4'b0100}) $display("FAIL xor got=%h/%b exp=00/0100", r, f); else pass_cnt++;
    run_op8(3'b001, 8'hFF, 8'hFF, r, f);
    chk_cnt++; if ({r, f} !== {8'h00, 4'b0100}) $display("FAIL op001 got=%h/%b exp=00/0100", r, f); else pass_cnt++;
    run_op8(3'b000, 8'h12, 8'h5A, r, f);
    chk_cnt++; if ({r, f} !== {8'h5A, 4'b0000}) $display("FAIL hold_b got=%h/%b exp=5a/0000", r, f); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [3:0] f;
    for (int i = 0; i < 16; i++)
      run_op8(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), r, f);
  endtask

  task automatic test_busy_start();
    int k;
    logic [67:0] exp_v, got;
    logic [7:0] r;
    logic [3:0] f;
    @(negedge clk);
    op8 = 3'b010; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    exp_q.push_back(model(8, 3'b010, 64'h12, 64'h34));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; op8 = 3'b110;
    k = 0;
    while (done8 !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 3) begin op8 = 3'b011; a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1; end
      else start8 = 1'b0;
    end
    start8 = 1'b0;
    chk_cnt++;
    if (k !== 9) $display("FAIL busy_start_latency got=%0d exp=9", k); else pass_cnt++;
    got = {56'd0, res8, n8, z8, c8, v8};
    chk_cnt++;
    if (exp_q.size() == 0) $display("FAIL sb8_empty got=%h", got);
    else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) $display("FAIL busy_start_result got=%h exp=%h", got, exp_v); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++;
    if ({busy8, done8} !== 2'b00) $display("FAIL busy_start_ignored busy/done got=%b%b exp=00", busy8, done8);
    else pass_cnt++;
    run_op8(3'b011, 8'hFF, 8'h01, r, f);
    chk_cnt++; if ({r, f} !== {8'hFE, 4'b1010}) $display("FAIL second_start got=%h/%b exp=fe/1010", r, f); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic [3:0] f;
    @(negedge clk);
    op8 = 3'b010; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy8, done8, res8, st8} !== '0)
      $display("FAIL reset_mid got busy=%b done=%b res=%h st=%0d exp=0", busy8, done8, res8, st8);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    run_op8(3'b010, 8'h03, 8'h04, r, f);
    chk_cnt++; if ({r, f} !== {8'h07, 4'b0000}) $display("FAIL add_after_reset got=%h/%b exp=07/0000", r, f); else pass_cnt++;
  endtask

  task automatic test_width64();
    logic [63:0] r;
    logic [3:0] f;
    run_op64(3'b011, 64'h8000_0000_0000_0000, 64'd1, r, f);
    chk_cnt++; if ({r, f} !== {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011}) $display("FAIL sub64 got=%h/%b exp=7fffffffffffffff/0011", r, f); else pass_cnt++;
    run_op64(3'b111, 64'hDEAD_BEEF_0000_0001, 64'h1234, r, f);
    chk_cnt++; if ({r, f} !== {64'd0, 4'b0100}) $display("FAIL op111_64 got=%h/%b exp=0/0100", r, f); else pass_cnt++;
    for (int i = 0; i < 4; i++)
      run_op64(3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()}, r, f);
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_random();
    test_busy_start();
    test_reset_mid();
    test_width64();
    chk_cnt++;
    if (exp_q.size() + exp64_q.size() != 0)
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size() + exp64_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
